// File: rtl/zbt_edge_writer.sv
// -----------------------------------------------------------------------------
// zbt_edge_writer
//
// Write-back packer for the edge-detection pipeline. Each incoming 24-bit RGB
// pixel is reduced to RGB 6:6:6 (optionally masked by the edge-select bit),
// even and odd columns are paired into one 36-bit ZBT word, finished words
// are queued in a small FIFO and drained to the ZBT write port only in cycles
// where the memory arbiter grants the write slot.
//
// Parameters
//   DEPTH       FIFO depth in 36-bit words (power of two, >= 2)
//   USE_SELECT  1: pixels with select_in=0 are written as zero
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   pix_valid   pixel inputs valid this cycle
//   pix_rgb     {R,G,B} 8 bits each
//   select_in   edge-select bit of this pixel
//   hcount      column; [9:1] word column, [0] even/odd
//   vcount      row
//   flush       pushes a pending half word (end of line/frame)
//   wr_grant    arbiter grants the ZBT write slot this cycle
//   zbt_we      one-cycle write strobe
//   zbt_addr    {vcount, hcount[9:1]} of the written word
//   zbt_data    {even pixel, odd pixel}
//   fifo_count  words currently held in the FIFO
//   overflow    sticky: a word was dropped on a full FIFO
//   pair_err    sticky: odd pixel did not match the pending even address
// -----------------------------------------------------------------------------
module zbt_edge_writer #(
   parameter int DEPTH      = 4,
   parameter bit USE_SELECT = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     pix_valid,
   input  logic [23:0]              pix_rgb,
   input  logic                     select_in,
   input  logic [10:0]              hcount,
   input  logic [9:0]               vcount,
   input  logic                     flush,
   input  logic                     wr_grant,
   output logic                     zbt_we,
   output logic [18:0]              zbt_addr,
   output logic [35:0]              zbt_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     pair_err
);

   localparam int AW     = $clog2(DEPTH);
   localparam int WORD_W = 55;   // {addr[18:0], data[35:0]}

   localparam logic [AW:0] ONE_C      = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   typedef enum logic {
      EMPTY     = 1'b0,
      HAVE_EVEN = 1'b1
   } state_t;

   // Reduce an RGB888 pixel to RGB666, masking unselected pixels when enabled.
   function automatic logic [17:0] reduce_pixel(input logic [23:0] rgb, input logic sel);
      logic [17:0] p;
      if (USE_SELECT && !sel) begin
         p = 18'h0;
      end else begin
         p = {rgb[23:18], rgb[15:10], rgb[7:2]};
      end
      return p;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [17:0]         pend_data_r;
   logic [18:0]         pend_addr_r;
   logic                pend_load_s;

   logic [17:0]         pix_p18_s;
   logic [18:0]         pix_addr_s;
   logic                pix_odd_s;

   logic                push_s;
   logic [WORD_W-1:0]   push_word_s;
   logic                pair_err_set_s;

   logic [WORD_W-1:0]   mem_r [DEPTH];
   logic [AW:0]         wr_ptr_r;
   logic [AW:0]         rd_ptr_r;
   logic [AW:0]         count_r;
   logic                overflow_r;
   logic                pair_err_r;
   logic                zbt_we_r;
   logic [18:0]         zbt_addr_r;
   logic [35:0]         zbt_data_r;

   logic                full_s;
   logic                empty_s;
   logic                pop_s;
   logic                push_ok_s;
   logic                unused_hcount_msb;

   // Column bit 10 lies outside the 9-bit word column and is not stored.
   assign unused_hcount_msb = hcount[10];

   assign pix_p18_s  = reduce_pixel(pix_rgb, select_in);
   assign pix_addr_s = {vcount, hcount[9:1]};
   assign pix_odd_s  = hcount[0];

   assign full_s    = (count_r == FULL_COUNT);
   assign empty_s   = (count_r == {(AW+1){1'b0}});
   assign pop_s     = wr_grant && !empty_s;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok_s = push_s && (!full_s || pop_s);

   // Pairing FSM next-state and push decode.
   always_comb begin
      state_nxt_s    = state_r;
      push_s         = 1'b0;
      push_word_s    = {WORD_W{1'b0}};
      pend_load_s    = 1'b0;
      pair_err_set_s = 1'b0;
      case (state_r)
         EMPTY: begin
            if (pix_valid) begin
               if (pix_odd_s) begin
                  // Orphan odd pixel: written alone at its own address.
                  push_s      = 1'b1;
                  push_word_s = {pix_addr_s, 18'h0, pix_p18_s};
               end else begin
                  pend_load_s = 1'b1;
                  state_nxt_s = HAVE_EVEN;
               end
            end else begin
               state_nxt_s = EMPTY;   // flush without a pending half is a no-op
            end
         end
         HAVE_EVEN: begin
            if (pix_valid) begin
               if (pix_odd_s) begin
                  push_s      = 1'b1;
                  state_nxt_s = EMPTY;
                  if (pix_addr_s == pend_addr_r) begin
                     push_word_s = {pend_addr_r, pend_data_r, pix_p18_s};
                  end else begin
                     // Mismatched odd pixel is dropped; the even half goes out alone.
                     push_word_s    = {pend_addr_r, pend_data_r, 18'h0};
                     pair_err_set_s = 1'b1;
                  end
               end else begin
                  push_s      = 1'b1;
                  push_word_s = {pend_addr_r, pend_data_r, 18'h0};
                  pend_load_s = 1'b1;
               end
            end else if (flush) begin
               push_s      = 1'b1;
               push_word_s = {pend_addr_r, pend_data_r, 18'h0};
               state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = HAVE_EVEN;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
         end
      endcase
   end

   // Pairing state and pending half-word register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= EMPTY;
         pend_data_r <= 18'h0;
         pend_addr_r <= 19'h0;
      end else begin
         state_r <= state_nxt_s;
         if (pend_load_s) begin
            pend_data_r <= pix_p18_s;
            pend_addr_r <= pix_addr_s;
         end
      end
   end

   // FIFO storage, pointers, occupancy and sticky error flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WORD_W{1'b0}};
         end
         wr_ptr_r   <= {(AW+1){1'b0}};
         rd_ptr_r   <= {(AW+1){1'b0}};
         count_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         pair_err_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
            wr_ptr_r                <= wr_ptr_r + ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
         if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
         if (pair_err_set_s) begin
            pair_err_r <= 1'b1;
         end
      end
   end

   // ZBT write port: one strobe per pop, address/data hold between writes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         zbt_we_r   <= 1'b0;
         zbt_addr_r <= 19'h0;
         zbt_data_r <= 36'h0;
      end else begin
         zbt_we_r <= pop_s;
         if (pop_s) begin
            {zbt_addr_r, zbt_data_r} <= mem_r[rd_ptr_r[AW-1:0]];
         end
      end
   end

   assign zbt_we     = zbt_we_r;
   assign zbt_addr   = zbt_addr_r;
   assign zbt_data   = zbt_data_r;
   assign fifo_count = count_r;
   assign overflow   = overflow_r;
   assign pair_err   = pair_err_r;

endmodule
